// File: rtl/echo_capture_pkg.sv
// echo_capture_pkg: shared state encoding and default widths for the echo capture front end.
package echo_capture_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, BLANK, CAPTURE, FINISH} stateT;
endpackage

// File: rtl/echo_capture_bin_reducer.sv
// bin_reducer: folds 2^DECIM_LOG2 samples into one bin value, peak hold by default
// or truncated mean when ECHO_CAPTURE_AVG_EN is defined.
module bin_reducer
    import echo_capture_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DECIM_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sampleEn,
    input  logic [DATA_W-1:0] sample,
    output logic              binDone,
    output logic [DATA_W-1:0] binValue
);
    localparam int CNT_W = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
`ifdef ECHO_CAPTURE_AVG_EN
    localparam int ACC_W = DATA_W + DECIM_LOG2;
`else
    localparam int ACC_W = DATA_W;
`endif

    logic [CNT_W-1:0] sampleCnt;
    logic [ACC_W-1:0] acc, accNext;
    logic             firstSample;

    assign firstSample = sampleCnt == '0;
    assign binDone     = sampleEn && sampleCnt == CNT_LAST;

    // The first sample of a bin replaces the accumulator so no stale data leaks in.
`ifdef ECHO_CAPTURE_AVG_EN
    assign accNext  = (firstSample ? '0 : acc) + ACC_W'(sample);
    assign binValue = DATA_W'(accNext >> DECIM_LOG2);
`else
    assign accNext  = firstSample || sample > acc ? sample : acc;
    assign binValue = accNext;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sampleCnt <= '0;
            acc       <= '0;
        end else if (sampleEn) begin
            sampleCnt <= binDone ? '0 : sampleCnt + 1'b1;
            acc       <= accNext;
        end
    end
endmodule

// File: rtl/echo_capture.sv
// echo_capture: blanks, decimates and writes one sonar scan line into the line buffer.
// Define ECHO_CAPTURE_AVG_EN to store the bin mean instead of the bin peak.
module echo_capture
    import echo_capture_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BINS          = 1024,
    parameter int DECIM_LOG2    = 2,
    parameter int BLANK_SAMPLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              sampleValid,
    input  logic [DATA_W-1:0] sampleData,
    output logic              busy,
    output logic              done,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData
);
    localparam int BLANK_W = BLANK_SAMPLES > 0 ? $clog2(BLANK_SAMPLES + 1) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_SAMPLES > 0 ? BLANK_SAMPLES - 1 : 0);
    localparam logic [ADDR_W-1:0] BIN_LAST = ADDR_W'(BINS - 1);

    stateT             state, stateNext;
    logic [BLANK_W-1:0] blankCnt;
    logic [ADDR_W-1:0]  binCnt, wrAddrNext;
    logic [DATA_W-1:0]  binValue, wrDataNext;
    logic               accept, sampleEn, binDone, busyNext, doneNext;

    // Abort outranks start, and also suppresses a bin completing in the same cycle.
    assign accept   = start && !abort;
    assign sampleEn = sampleValid && state == CAPTURE && !abort;

    bin_reducer #(
        .DATA_W    (DATA_W),
        .DECIM_LOG2(DECIM_LOG2)
    ) reducer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE || abort),
        .sampleEn(sampleEn),
        .sample  (sampleData),
        .binDone (binDone),
        .binValue(binValue)
    );

    always_ff @(posedge clk)
        state <= reset ? IDLE : stateNext;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = accept ? (BLANK_SAMPLES == 0 ? CAPTURE : BLANK) : IDLE;
            BLANK:   stateNext = abort ? IDLE : sampleValid && blankCnt == BLANK_LAST ? CAPTURE : BLANK;
            CAPTURE: stateNext = abort ? IDLE : binDone && binCnt == BIN_LAST ? FINISH : CAPTURE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busyNext   = state == IDLE ? accept : state != FINISH && !abort;
        doneNext   = state == FINISH && !abort;
        wrAddrNext = binDone ? binCnt : wrAddr;
        wrDataNext = binDone ? binValue : wrData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blankCnt <= '0;
            binCnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
        end else begin
            blankCnt <= state == IDLE ? '0 : state == BLANK && sampleValid ? blankCnt + 1'b1 : blankCnt;
            binCnt   <= state == IDLE ? '0 : binDone ? binCnt + 1'b1 : binCnt;
            busy     <= busyNext;
            done     <= doneNext;
            wrEn     <= binDone;
            wrAddr   <= wrAddrNext;
            wrData   <= wrDataNext;
        end
    end
endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: scoreboard bench for echo_capture in a ramp/peak configuration and a 4-bin edge configuration.
module tb_echo_capture;
    typedef struct {int addr; int data; int cyc;} expT;
`ifdef ECHO_CAPTURE_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, start, abort, sampleValid, startB, validB;
    logic [7:0] sampleData, dataB;
    logic       busyA, doneA, wrEnA, busyB, doneB, wrEnB;
    logic [9:0] wrAddrA;
    logic [1:0] wrAddrB;
    logic [7:0] wrDataA, wrDataB;

    echo_capture #(.ADDR_W(10), .DATA_W(8), .BINS(60), .DECIM_LOG2(2), .BLANK_SAMPLES(16)) dutA (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .sampleValid(sampleValid),
        .sampleData(sampleData), .busy(busyA), .done(doneA), .wrEn(wrEnA), .wrAddr(wrAddrA), .wrData(wrDataA)
    );

    echo_capture #(.ADDR_W(2), .DATA_W(8), .BINS(4), .DECIM_LOG2(0), .BLANK_SAMPLES(0)) dutB (
        .clk(clk), .reset(reset), .start(startB), .abort(1'b0), .sampleValid(validB),
        .sampleData(dataB), .busy(busyB), .done(doneB), .wrEn(wrEnB), .wrAddr(wrAddrB), .wrData(wrDataB)
    );

    int  checks = 0, errors = 0;
    expT qA[$], qB[$];
    int  doneCntA = 0, doneCntB = 0, doneCycB = -1, lastCycB;
    int  blankLeft, nIn, peak, sum, binIdx;
    bit  live;
    int  bData[4] = '{5, 9, 3, 250};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        expT e;
        if (doneA) begin
            doneCntA++;
            check("A busy with done", busyA, 0);
        end
        if (wrEnA) begin
            if (qA.size() == 0) check("A unexpected write", wrAddrA, -1);
            else begin
                e = qA.pop_front();
                check("A wrAddr", wrAddrA, e.addr);
                check("A wrData", wrDataA, e.data);
                check("A write cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        expT e;
        if (doneB) begin
            doneCntB++;
            doneCycB = cyc;
            check("B busy with done", busyB, 0);
        end
        if (wrEnB) begin
            if (qB.size() == 0) check("B unexpected write", wrAddrB, -1);
            else begin
                e = qB.pop_front();
                check("B wrAddr", wrAddrB, e.addr);
                check("B wrData", wrDataB, e.data);
                check("B write cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pingA();
        start = 1'b1;
        blankLeft = 16;
        nIn = 0;
        binIdx = 0;
        live = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("A busy after start", busyA, 1);
    endtask

    // Model: blank 16 samples, then every 4 samples give one expected write one cycle after the 4th strobe.
    task automatic feedA(input int d, input bit st = 1'b0, input bit ab = 1'b0);
        sampleValid = 1'b1;
        sampleData = d[7:0];
        start = st;
        abort = ab;
        if (ab) live = 1'b0;
        else if (live && blankLeft > 0) blankLeft--;
        else if (live) begin
            peak = (nIn == 0 || d > peak) ? d : peak;
            sum = (nIn == 0 ? 0 : sum) + d;
            nIn++;
            if (nIn == 4) begin
                qA.push_back('{binIdx, AVG ? sum >> 2 : peak, cyc + 1});
                binIdx++;
                nIn = 0;
                if (binIdx == 60) live = 1'b0;
            end
        end
        @(posedge clk); #1;
        sampleValid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic checkIdleA(input string tag);
        check({tag, " busy"}, busyA, 0);
        check({tag, " done"}, doneA, 0);
        check({tag, " wrEn"}, wrEnA, 0);
        check({tag, " wrAddr"}, wrAddrA, 0);
        check({tag, " wrData"}, wrDataA, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sampleValid = 1'b0;
        sampleData = '0;
        startB = 1'b0;
        validB = 1'b0;
        dataB = '0;
        live = 1'b0;
        repeat (2) @(posedge clk); #1;
        checkIdleA("reset");
        check("B reset busy", busyB, 0);
        reset = 1'b0;

        pingA();
        for (int i = 0; i < 256; i++) feedA(i);
        repeat (3) @(negedge clk);
        check("ramp done count", doneCntA, 1);
        check("ramp writes drained", qA.size(), 0);
        check("ramp busy after line", busyA, 0);

        pingA();
        for (int i = 0; i < 16; i++) feedA(int'($urandom_range(0, 255)));
        feedA(10); feedA(200); feedA(7); feedA(50);
        for (int i = 0; i < 19; i++) feedA(int'($urandom_range(0, 255)));
        feedA(99, 1'b0, 1'b1);
        check("abort busy", busyA, 0);
        check("abort wrEn", wrEnA, 0);
        repeat (4) @(negedge clk);
        check("abort no done", doneCntA, 1);
        check("abort writes drained", qA.size(), 0);

        pingA();
        for (int i = 0; i < 256; i++) feedA(int'($urandom_range(0, 255)), i == 24);
        repeat (3) @(negedge clk);
        check("restart-ignored done count", doneCntA, 2);
        check("restart-ignored writes drained", qA.size(), 0);

        pingA();
        for (int i = 0; i < 22; i++) feedA(i);
        live = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkIdleA("mid reset");
        for (int i = 0; i < 8; i++) feedA(i + 100);
        repeat (3) @(negedge clk);
        check("post reset writes drained", qA.size(), 0);
        check("post reset done count", doneCntA, 2);

        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        check("B busy after start", busyB, 1);
        for (int i = 0; i < 4; i++) begin
            validB = 1'b1;
            dataB = bData[i][7:0];
            qB.push_back('{i, bData[i], cyc + 1});
            lastCycB = cyc;
            @(posedge clk); #1;
        end
        validB = 1'b0;
        repeat (4) @(negedge clk);
        check("B done count", doneCntB, 1);
        check("B done cycle", doneCycB, lastCycB + 2);
        check("B writes drained", qB.size(), 0);
        check("B busy after line", busyB, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
